ysyx_24080014_ifu: RTL and testbench
====================================

YSYX_24080014_IFU -- requirements
Module: ysyx_24080014_ifu

Interface
REQ-001 Parameter RESET_PC SHALL default to 32'h8000_0000 and set the PC value loaded on reset.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-004 Port next_pc  input  32  SHALL carry the next PC from the jump stage, sampled only on an instruction handshake.
REQ-005 Port imem_req_valid  output  1  SHALL flag a fetch request.
REQ-006 Port imem_req_ready  input  1  SHALL flag that memory accepts the request.
REQ-007 Port imem_addr  output  32  SHALL carry the fetch address, equal to pc.
REQ-008 Port imem_resp_valid  input  1  SHALL flag that return data is valid.
REQ-009 Port imem_resp_data  input  32  SHALL carry the instruction word.
REQ-010 Port imem_resp_err  input  1  SHALL flag an access fault on the response.
REQ-011 Port pc  output  32  SHALL carry the PC of the current fetch or held instruction.
REQ-012 Port inst  output  32  SHALL carry the latched instruction.
REQ-013 Port inst_valid  output  1  SHALL flag that inst and pc are valid for the decode stage.
REQ-014 Port inst_ready  input  1  SHALL flag that the decode/execute path consumes the instruction.
REQ-015 Port fetch_err  output  1  SHALL flag that the held instruction came with imem_resp_err.
REQ-016 Port misalign  output  1  SHALL flag a misaligned-PC fault (REQ-032).
REQ-017 Port fetch_cnt  output  32  SHALL count completed instruction handshakes.

Function
REQ-018 FSM states SHALL be S_REQ, S_WAIT, S_HOLD and S_FAULT.
REQ-019 S_REQ: imem_req_valid=1; on imem_req_ready=1 go to S_WAIT next cycle, else stay.
REQ-020 S_WAIT: imem_req_valid=0; on imem_resp_valid=1 latch inst<=imem_resp_data and fetch_err<=imem_resp_err, then go to S_HOLD.
REQ-021 imem_resp_valid SHALL be ignored in every state except S_WAIT, including the cycle the request is accepted.
REQ-022 S_HOLD: inst_valid=1; inst, pc and fetch_err SHALL stay stable until the handshake.
REQ-023 The handshake is inst_valid and inst_ready both 1 in one cycle; on it: pc<=next_pc, fetch_cnt<=fetch_cnt+1, go to S_REQ.
REQ-024 inst_valid SHALL be 0 in all states other than S_HOLD.
REQ-025 Minimum latency: request in cycle N, response in N+1, inst_valid in N+2, next request in N+3 when inst_ready is already 1.
REQ-026 fetch_cnt SHALL wrap from 32'hFFFF_FFFF to 0 without any flag.
REQ-027 inst_ready while not in S_HOLD SHALL have no effect.

Reset
REQ-028 When rst=1 at a clock edge: pc=RESET_PC, state=S_REQ, inst=0, fetch_err=0, misalign=0, fetch_cnt=0.
REQ-029 Reset in any state, including S_WAIT with a response outstanding, SHALL abandon the fetch. Any response arriving afterwards outside S_WAIT is ignored.
REQ-030 imem_req_valid SHALL be 0 while rst=1 and SHALL assert in the first cycle after rst falls.

Configuration
REQ-031 Macro YSYX_24080014_IFU_MISALIGN_CHECK_EN SHALL enable PC alignment checking.
REQ-032 When defined: if a handshake loads next_pc with next_pc[1:0]!=0, then pc is still updated, misalign<=1 and the state goes to S_FAULT. S_FAULT issues no requests, keeps inst_valid=0, and is left only by reset.
REQ-033 When undefined: misalign SHALL be tied to 0, S_FAULT is unreachable, and imem_addr carries all 32 PC bits unchanged.

Verification
REQ-034 Reset release, imem_req_ready=1, response 32'h0000_0413 one cycle later, inst_ready=1 -> imem_addr=32'h8000_0000, inst_valid at cycle 2, fetch_cnt=1, next imem_addr=next_pc.
REQ-035 imem_req_ready held 0 for 5 cycles -> imem_req_valid=1 and imem_addr stable throughout; no state advance.
REQ-036 inst_ready held 0 for 4 cycles in S_HOLD with next_pc toggling -> inst, pc and inst_valid unchanged; pc updates only on the handshake.
REQ-037 Response with imem_resp_err=1 -> fetch_err=1 with inst_valid; cleared to 0 by the next good response.
REQ-038 rst asserted in S_WAIT, then a stale imem_resp_valid arrives in S_REQ -> ignored; pc=RESET_PC and fetch_cnt=0.
REQ-039 With the macro defined, handshake with next_pc=32'h8000_0006 -> misalign=1, no further imem_req_valid. Without the macro -> fetch issued at 32'h8000_0006.

Source files
------------

// File: rtl/ysyx_24080014_ifu.sv
// ysyx_24080014_ifu: single-outstanding instruction fetch unit (req -> wait -> hold)
// Define YSYX_24080014_IFU_MISALIGN_CHECK_EN to trap misaligned PCs in S_FAULT.
module ysyx_24080014_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        fetch_err,
  output logic        misalign,
  output logic [31:0] fetch_cnt
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_FAULT} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, inst_q, inst_d, cnt_q, cnt_d;
  logic        ferr_q, ferr_d, mis_q, mis_d, bad_pc;
`ifdef YSYX_24080014_IFU_MISALIGN_CHECK_EN
  assign bad_pc = |next_pc[1:0];
`else
  assign bad_pc = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    ferr_d  = ferr_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;
    case (state_q)
      S_REQ:  state_d = imem_req_ready ? S_WAIT : S_REQ;
      S_WAIT: if (imem_resp_valid) begin
        inst_d  = imem_resp_data;
        ferr_d  = imem_resp_err;
        state_d = S_HOLD;
      end
      S_HOLD: if (inst_ready) begin
        pc_d    = next_pc;
        cnt_d   = cnt_q + 32'd1;
        mis_d   = bad_pc;
        state_d = bad_pc ? S_FAULT : S_REQ;
      end
      default: state_d = S_FAULT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      inst_q  <= 32'd0;
      ferr_q  <= 1'b0;
      cnt_q   <= 32'd0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      ferr_q  <= ferr_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
    end
  end
  // Request is gated by rst so nothing leaks out while reset is held.
  assign imem_req_valid = (state_q == S_REQ) && !rst;
  assign imem_addr      = pc_q;
  assign pc             = pc_q;
  assign inst           = inst_q;
  assign inst_valid     = state_q == S_HOLD;
  assign fetch_err      = ferr_q;
  assign misalign       = mis_q;
  assign fetch_cnt      = cnt_q;
endmodule

// File: tb/tb_ysyx_24080014_ifu.sv
// tb_ysyx_24080014_ifu: directed vector table plus reset/misalign sequences for the IFU.
module tb_ysyx_24080014_ifu;
  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] next_pc = 32'd0, imem_addr, imem_resp_data = 32'd0, pc, inst, fetch_cnt;
  logic        imem_req_valid, imem_req_ready = 1'b0, imem_resp_valid = 1'b0, imem_resp_err = 1'b0;
  logic        inst_valid, inst_ready = 1'b0, fetch_err, misalign;
  int          n_run = 0, n_fail = 0;

  ysyx_24080014_ifu dut (
    .clk(clk), .rst(rst), .next_pc(next_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data), .imem_resp_err(imem_resp_err),
    .pc(pc), .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .fetch_err(fetch_err), .misalign(misalign), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy, rv, re, ir;
    logic [31:0] rd, npc;
    logic        e_rv, e_iv, e_fe;
    logic [31:0] e_addr, e_inst, e_cnt;
  } vec_t;
  vec_t v[$];

  function automatic vec_t mk(logic rdy, logic rv, logic [31:0] rd, logic re, logic ir, logic [31:0] npc,
                              logic e_rv, logic [31:0] e_addr, logic e_iv, logic [31:0] e_inst,
                              logic e_fe, logic [31:0] e_cnt);
    mk = '{rdy: rdy, rv: rv, re: re, ir: ir, rd: rd, npc: npc,
           e_rv: e_rv, e_iv: e_iv, e_fe: e_fe, e_addr: e_addr, e_inst: e_inst, e_cnt: e_cnt};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic rdy, logic rv, logic [31:0] rd, logic re, logic ir, logic [31:0] npc);
    imem_req_ready = rdy; imem_resp_valid = rv; imem_resp_data = rd;
    imem_resp_err = re; inst_ready = ir; next_pc = npc;
  endtask

  initial begin
    // Cycle 0 is the first cycle after reset release.
    v.push_back(mk(1, 0, 0, 0, 0, 0,                    1, 32'h8000_0000, 0, 0, 0, 0));
    v.push_back(mk(0, 1, 32'h0000_0413, 0, 0, 0,        0, 32'h8000_0000, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 1, 32'h8000_0004,        0, 32'h8000_0000, 1, 32'h0000_0413, 0, 0));
    for (int i = 0; i < 5; i++)
      v.push_back(mk(0, 1, 32'hBAD0_0001, 1, 1, 0,      1, 32'h8000_0004, 0, 32'h0000_0413, 0, 1));
    v.push_back(mk(1, 1, 32'hBAD0_0002, 1, 0, 0,        1, 32'h8000_0004, 0, 32'h0000_0413, 0, 1));
    v.push_back(mk(0, 0, 0, 0, 0, 0,                    0, 32'h8000_0004, 0, 32'h0000_0413, 0, 1));
    v.push_back(mk(0, 1, 32'hDEAD_BEEF, 1, 0, 0,        0, 32'h8000_0004, 0, 32'h0000_0413, 0, 1));
    v.push_back(mk(0, 0, 0, 0, 0, 32'h1111_1110,        0, 32'h8000_0004, 1, 32'hDEAD_BEEF, 1, 1));
    v.push_back(mk(0, 1, 0, 0, 0, 32'h2222_2220,        0, 32'h8000_0004, 1, 32'hDEAD_BEEF, 1, 1));
    v.push_back(mk(0, 0, 0, 0, 0, 32'h3333_3330,        0, 32'h8000_0004, 1, 32'hDEAD_BEEF, 1, 1));
    v.push_back(mk(0, 0, 0, 0, 0, 32'h4444_4440,        0, 32'h8000_0004, 1, 32'hDEAD_BEEF, 1, 1));
    v.push_back(mk(0, 0, 0, 0, 1, 32'h8000_0010,        0, 32'h8000_0004, 1, 32'hDEAD_BEEF, 1, 1));
    v.push_back(mk(1, 0, 0, 0, 0, 0,                    1, 32'h8000_0010, 0, 32'hDEAD_BEEF, 1, 2));
    v.push_back(mk(0, 1, 32'h0000_0013, 0, 0, 0,        0, 32'h8000_0010, 0, 32'hDEAD_BEEF, 1, 2));
    v.push_back(mk(0, 0, 0, 0, 1, 32'h8000_0006,        0, 32'h8000_0010, 1, 32'h0000_0013, 0, 2));

    tick();
    chk("req_valid_in_reset", imem_req_valid, 0);
    tick();
    chk("req_valid_in_reset2", imem_req_valid, 0);
    rst = 1'b0;

    foreach (v[k]) begin
      drive(v[k].rdy, v[k].rv, v[k].rd, v[k].re, v[k].ir, v[k].npc);
      #1;
      chk($sformatf("v%0d_req_valid", k), imem_req_valid, v[k].e_rv);
      chk($sformatf("v%0d_addr", k), imem_addr, v[k].e_addr);
      chk($sformatf("v%0d_pc", k), pc, v[k].e_addr);
      chk($sformatf("v%0d_inst_valid", k), inst_valid, v[k].e_iv);
      chk($sformatf("v%0d_inst", k), inst, v[k].e_inst);
      chk($sformatf("v%0d_fetch_err", k), fetch_err, v[k].e_fe);
      chk($sformatf("v%0d_cnt", k), fetch_cnt, v[k].e_cnt);
      chk($sformatf("v%0d_misalign", k), misalign, 0);
      tick();
    end

    // Handshake just loaded the misaligned PC 8000_0006.
    drive(1, 1, 32'h0000_0093, 0, 1, 0);
    #1;
    chk("mis_pc", pc, 32'h8000_0006);
    chk("mis_cnt", fetch_cnt, 3);
    chk("mis_inst_valid", inst_valid, 0);
`ifdef YSYX_24080014_IFU_MISALIGN_CHECK_EN
    chk("mis_flag", misalign, 1);
    chk("mis_no_req", imem_req_valid, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fault_no_req", imem_req_valid, 0);
      chk("fault_no_inst", inst_valid, 0);
      chk("fault_flag", misalign, 1);
    end
`else
    chk("mis_flag_off", misalign, 0);
    chk("mis_req", imem_req_valid, 1);
    chk("mis_addr", imem_addr, 32'h8000_0006);
    tick();
    chk("wait_after_mis", imem_req_valid, 0);
`endif

    // Reset while a fetch is outstanding, then a stale response in S_REQ.
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("rst_req_gated", imem_req_valid, 0);
    tick();
    rst = 1'b0;
    drive(0, 1, 32'hCAFE_F00D, 1, 1, 32'h1234_5678);
    #1;
    chk("rst_pc", pc, 32'h8000_0000);
    chk("rst_cnt", fetch_cnt, 0);
    chk("rst_inst", inst, 0);
    chk("rst_ferr", fetch_err, 0);
    chk("rst_misalign", misalign, 0);
    chk("rst_req_valid", imem_req_valid, 1);
    chk("rst_inst_valid", inst_valid, 0);
    tick();
    chk("stale_ignored_req", imem_req_valid, 1);
    chk("stale_ignored_iv", inst_valid, 0);
    chk("stale_ignored_inst", inst, 0);
    drive(1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 1, 32'h0010_0093, 0, 1, 32'h8000_0004);
    tick();
    chk("post_rst_iv", inst_valid, 1);
    chk("post_rst_inst", inst, 32'h0010_0093);
    tick();
    chk("post_rst_cnt", fetch_cnt, 1);
    chk("post_rst_addr", imem_addr, 32'h8000_0004);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
